// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the unified IF/MEM memory port arbiter.
// Also holds the requester IDs and the width of the latency counter.
package mem_port_arbiter_pkg;

    typedef enum logic [2:0] {
        ARB_IDLE     = 3'd0,
        ARB_BUSY_IF  = 3'd1,
        ARB_BUSY_MEM = 3'd2,
        ARB_DONE_IF  = 3'd3,
        ARB_DONE_MEM = 3'd4
    } arb_state_t;

    typedef logic req_id_t;

    localparam req_id_t REQ_IF  = 1'b0;
    localparam req_id_t REQ_MEM = 1'b1;

    // Wide enough for the largest legal latency (15 cycles).
    localparam int TIMER_W = 4;

endpackage

// File: rtl/mem_port_arbiter_access_timer.sv
// Loadable down-counter for fixed-latency units.
// The done flag is high whenever the count has reached zero.
module access_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             done
);

    logic [CNT_W-1:0] count;

    // Holding at zero means the counter can never wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates IF fetches and MEM loads/stores onto one fixed-latency RAM port.
// It returns per-requester ready pulses and read data, plus the pipeline stall signals.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    input  logic              if_flush_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_ready_o,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    output logic [DATA_W-1:0] mem_rdata_o,
    output logic              mem_ready_o,
    output logic              ram_en_o,
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    input  logic [DATA_W-1:0] ram_rdata_i,
    output logic              stall_if_o,
    output logic              stall_mem_o
);

    localparam logic [TIMER_W-1:0] LOAD_VAL = TIMER_W'(MEM_LAT - 1);

    arb_state_t state;
    logic       discard;
    logic       grant_vld;
    req_id_t    grant_id;
    logic       busy;
    logic       timer_done;

    // A requester that is being answered this cycle still shows its old request,
    // so it sits out arbitration; this also yields alternation under contention.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = REQ_IF;
        if (state == ARB_IDLE || state == ARB_DONE_IF || state == ARB_DONE_MEM) begin
            if (mem_req_i && state != ARB_DONE_MEM) begin
                grant_vld = 1'b1;
                grant_id  = REQ_MEM;
            end else if (if_req_i && state != ARB_DONE_IF) begin
                grant_vld = 1'b1;
                grant_id  = REQ_IF;
            end
        end
    end

    assign busy = (state == ARB_BUSY_IF) || (state == ARB_BUSY_MEM);

    access_timer #(
        .CNT_W(TIMER_W)
    ) u_timer (
        .clk     (clk_i),
        .rst     (rst_i),
        .load    (grant_vld),
        .load_val(LOAD_VAL),
        .en      (busy),
        .done    (timer_done)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= ARB_IDLE;
            discard     <= 1'b0;
            if_ready_o  <= 1'b0;
            mem_ready_o <= 1'b0;
            if_rdata_o  <= '0;
            mem_rdata_o <= '0;
            ram_en_o    <= 1'b0;
            ram_we_o    <= 1'b0;
            ram_addr_o  <= '0;
            ram_wdata_o <= '0;
        end else begin
            if_ready_o  <= 1'b0;
            mem_ready_o <= 1'b0;
            case (state)
                ARB_IDLE, ARB_DONE_IF, ARB_DONE_MEM: begin
                    if (state == ARB_DONE_IF) begin
                        discard <= 1'b0;
                    end
                    if (grant_vld) begin
                        ram_en_o <= 1'b1;
                        if (grant_id == REQ_MEM) begin
                            state       <= ARB_BUSY_MEM;
                            ram_we_o    <= mem_we_i;
                            ram_addr_o  <= mem_addr_i;
                            ram_wdata_o <= mem_wdata_i;
                        end else begin
                            state      <= ARB_BUSY_IF;
                            ram_we_o   <= 1'b0;
                            ram_addr_o <= if_addr_i;
                        end
                    end else begin
                        state <= ARB_IDLE;
                    end
                end
                ARB_BUSY_IF: begin
                    // The RAM access cannot be cancelled; a flush only hides its result.
                    if (if_flush_i) begin
                        discard <= 1'b1;
                    end
                    if (timer_done) begin
                        state    <= ARB_DONE_IF;
                        ram_en_o <= 1'b0;
                        if (!(discard || if_flush_i)) begin
                            if_ready_o <= 1'b1;
                            if_rdata_o <= ram_rdata_i;
                        end
                    end
                end
                ARB_BUSY_MEM: begin
                    if (timer_done) begin
                        state       <= ARB_DONE_MEM;
                        ram_en_o    <= 1'b0;
                        ram_we_o    <= 1'b0;
                        mem_ready_o <= 1'b1;
                        if (!ram_we_o) begin
                            mem_rdata_o <= ram_rdata_i;
                        end
                    end
                end
                default: begin
                    state <= ARB_IDLE;
                end
            endcase
        end
    end

    assign stall_mem_o = mem_req_i & ~mem_ready_o;
    assign stall_if_o  = (if_req_i & ~if_ready_o) | stall_mem_o;

endmodule
